// File: rtl/alu_pkg.sv
// Shared ALU control codes, multiplier state encoding and widths.
package alu_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned ALU_CTL_W = 4;

    localparam logic [ALU_CTL_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_CTL_W-1:0] ALU_ORR   = 4'b0001;
    localparam logic [ALU_CTL_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [ALU_CTL_W-1:0] ALU_PASSB = 4'b0111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(63);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // True when ctl is one of the codes the external ALU understands.
    function automatic logic is_alu_code(input logic [ALU_CTL_W-1:0] ctl);
        return (ctl == ALU_AND) || (ctl == ALU_ORR) || (ctl == ALU_ADD) ||
               (ctl == ALU_SUB) || (ctl == ALU_PASSB);
    endfunction

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add 64x64 multiplier (low 64 bits) driving a shared external ALU.
// Optional build macro: MUL_SEQ_EARLY_TERM_EN -- stop iterating once the
// remaining multiplier bits are all zero.
module mul_seq
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    op_a,
    input  logic [DATA_W-1:0]    op_b,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    product,
    output logic                 prod_zero,
    output logic [ALU_CTL_W-1:0] alu_cnt,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zero
);

    mul_state_t         state, state_next;
    logic [DATA_W-1:0]  acc, acc_next;
    logic [DATA_W-1:0]  mcand, mcand_next;
    logic [DATA_W-1:0]  mplr, mplr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               prod_zero_next;
    logic [DATA_W-1:0]  mplr_shr;
    logic               last;

    assign mplr_shr = mplr >> 1;
    assign product  = acc;

    // Final RUN iteration detection.
    always_comb begin
`ifdef MUL_SEQ_EARLY_TERM_EN
        last = (cnt == CNT_LAST) || (mplr_shr == '0);
`else
        last = (cnt == CNT_LAST);
`endif
    end

    // State and datapath registers; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            cnt       <= '0;
            prod_zero <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            mcand     <= mcand_next;
            mplr      <= mplr_next;
            cnt       <= cnt_next;
            prod_zero <= prod_zero_next;
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
        end
    end

    // Next-state, datapath update and ALU request decode.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        mcand_next     = mcand;
        mplr_next      = mplr;
        cnt_next       = cnt;
        prod_zero_next = prod_zero;
        alu_cnt        = ALU_PASSB;
        alu_in1        = '0;
        alu_in2        = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = '0;
                    mcand_next = op_a;
                    mplr_next  = op_b;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                alu_cnt    = ALU_ADD;
                alu_in1    = acc;
                alu_in2    = mplr[0] ? mcand : '0;
                acc_next   = alu_result;
                mcand_next = mcand << 1;
                mplr_next  = mplr_shr;
                cnt_next   = cnt + CNT_W'(1);
                if (last) begin
                    state_next     = DONE;
                    prod_zero_next = alu_zero;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq with a behavioural model of the shared ALU.
module tb_mul_seq;
    import alu_pkg::*;

`ifdef MUL_SEQ_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        busy, done, prod_zero;
    logic [63:0] product, alu_in1, alu_in2, alu_result;
    logic [3:0]  alu_cnt;
    logic        alu_zero;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] prod;
        logic        zero;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] prod;
    } vec_t;

    mul_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .prod_zero  (prod_zero),
        .alu_cnt    (alu_cnt),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    // External ALU model.
    always_comb begin
        case (alu_cnt)
            ALU_ADD:   alu_result = alu_in1 + alu_in2;
            ALU_SUB:   alu_result = alu_in1 - alu_in2;
            ALU_AND:   alu_result = alu_in1 & alu_in2;
            ALU_ORR:   alu_result = alu_in1 | alu_in2;
            ALU_PASSB: alu_result = alu_in2;
            default:   alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 64'd0);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int run_cycles(input logic [63:0] b);
        int m = 0;
        for (int i = 0; i < 64; i++) if (b[i]) m = i + 1;
        if (!EARLY) return 64;
        return (m == 0) ? 1 : m;
    endfunction

    // One multiply from IDLE; poke>0 pulses start in that RUN cycle, poke<0 in the DONE cycle.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] prod_exp, input int poke);
        exp_t e;
        exp_t got;
        int   k;
        bit   seen;
        e.prod = prod_exp;
        e.zero = (prod_exp == 64'd0);
        e.cyc  = run_cycles(b) + 1;
        sb_q.push_back(e);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < 200) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == 1) begin
                check("busy_run", 64'(busy), 64'd1);
                check("alu_cnt_run", 64'(alu_cnt), 64'(ALU_ADD));
                check("alu_in1_run", alu_in1, 64'd0);
                check("alu_in2_run", alu_in2, b[0] ? a : 64'd0);
            end
            if (done) begin
                seen = 1'b1;
                got  = sb_q.pop_front();
                check("done_cycle", 64'(k), 64'(got.cyc));
                check("product", product, got.prod);
                check("prod_zero", 64'(prod_zero), 64'(got.zero));
                check("busy_done", 64'(busy), 64'd1);
            end else if (poke > 0 && k == poke) begin
                start = 1'b1;
                op_a  = 64'd9;
                op_b  = 64'd3;
            end
        end
        if (!seen) begin
            check("done_timeout", 64'(k), 64'(e.cyc));
            void'(sb_q.pop_front());
        end
        if (poke < 0) begin
            start = 1'b1;
            op_a  = 64'd9;
            op_b  = 64'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("alu_cnt_idle", 64'(alu_cnt), 64'(ALU_PASSB));
        check("product_hold", product, prod_exp);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        logic [63:0] ra, rb;

        vecs[0] = '{64'd3, 64'd5, 64'd15};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{64'd7, 64'd0, 64'd0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd2, 64'd0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vecs[5] = '{64'h8000_0000_0000_0001, 64'd3, 64'h8000_0000_0000_0003};
        vecs[6] = '{64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        vecs[7] = '{64'h0123_4567_89AB_CDEF, 64'd1, 64'h0123_4567_89AB_CDEF};

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_prod_zero", 64'(prod_zero), 64'd1);
        check("rst_alu_cnt", 64'(alu_cnt), 64'(ALU_PASSB));
        check("rst_alu_in1", alu_in1, 64'd0);
        check("rst_alu_in2", alu_in2, 64'd0);

        // Table vectors, issued back to back.
        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].prod, 0);

        // Product holds through idle cycles.
        repeat (5) @(negedge clk);
        check("idle_hold", product, vecs[7].prod);

        // Random operands against the multiply model.
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i[0]) rb = rb >> $urandom_range(60, 20);
            run_op(ra, rb, ra * rb, 0);
        end

        // Start during RUN and during DONE is ignored.
        run_op(64'd3, 64'hFFFF_FFFF, 64'h0000_0002_FFFF_FFFD, 2);
        run_op(64'd5, 64'd6, 64'd30, -1);
        @(negedge clk);
        check("done_start_ignored", 64'(busy), 64'd0);

        // Reset wins over start.
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 64'd3;
        op_b  = 64'd5;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        check("rst_prio_product", product, 64'd0);

        // Reset mid-RUN aborts without a done pulse.
        op_a  = 64'd3;
        op_b  = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_prod_zero", 64'(prod_zero), 64'd1);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", 64'(n), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
